p405s_icu_tag_init_seq: RTL and testbench

- Upstream command stage for the 16K ICU tag array.
- Arbitrates the tag-array port between three sources and drives the array's control and data inputs from registers.
- Sources, highest priority first: a hardware invalidate sweep (run after reset and on `iccciReq`), line-fill tag writes, and lookup reads.
- One array command is issued per cycle.

---
 rtl/p405s_icu_tag_init_seq_pkg.sv | 36 +++
 rtl/p405s_icu_tag_init_seq_if.sv | 47 ++++
 rtl/p405s_icu_tag_init_seq_parity.sv | 12 +
 rtl/p405s_icu_tag_init_seq.sv | 122 ++++++++++++
 tb/tb_p405s_icu_tag_init_seq.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/p405s_icu_tag_init_seq_pkg.sv
// p405s_icu_tag_init_seq_pkg: shared types and constants for the ICU tag
// command stage (state encodings, tag geometry, invalidate value, flags).
package p405s_icu_tag_init_seq_pkg;

  localparam int ICU_TAG_W     = 22;
  localparam int ICU_TAG_IDX_W = 8;

  localparam logic [ICU_TAG_W-1:0] ICU_TAG_INV = 22'h0;

  typedef enum logic [1:0] {
    ICU_TIS_IDLE    = 2'd0,
    ICU_TIS_SWEEP_A = 2'd1,
    ICU_TIS_SWEEP_B = 2'd2,
    ICU_TIS_DONE    = 2'd3
  } tis_state_e;

  // Single-bit array controls and handshake pulses, registered together.
  typedef struct packed {
    logic cyc;
    logic rd;
    logic ack;
    logic gnt;
    logic busy;
    logic done;
  } tis_flags_t;

  localparam tis_flags_t TIS_FLAGS_RST = '{
    cyc:  1'b0,
    rd:   1'b1,
    ack:  1'b0,
    gnt:  1'b0,
    busy: 1'b1,
    done: 1'b0
  };

endpackage

// File: rtl/p405s_icu_tag_init_seq_if.sv
// p405s_icu_tag_init_seq_if: request side (invalidate, fill, lookup) and
// array command side of the tag command stage. slave = stage, master = user.
interface p405s_icu_tag_init_seq_if #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 22
);

  logic             iccciReq;
  logic             fillTagWrReq;
  logic [0:IDX_W]   fillTagIndex;
  logic [0:TAG_W-1] fillTagData;
  logic             fillWayB;
  logic             lookupReq;
  logic [0:IDX_W]   lookupIndex;

  logic             tagCycle;
  logic             readWr;
  logic [0:IDX_W]   tagIndex;
  logic [0:TAG_W-1] dataIn;
  logic             dataInParityBit;
  logic [0:TAG_W]   writeTagANotB;
  logic             fillTagWrAck;
  logic             lookupGnt;
  logic             iccciBusy;
  logic             iccciDone;

  modport slave (
    input  iccciReq, fillTagWrReq, fillTagIndex,
    input  fillTagData, fillWayB,
    input  lookupReq, lookupIndex,
    output tagCycle, readWr, tagIndex, dataIn,
    output dataInParityBit, writeTagANotB,
    output fillTagWrAck, lookupGnt,
    output iccciBusy, iccciDone
  );

  modport master (
    output iccciReq, fillTagWrReq, fillTagIndex,
    output fillTagData, fillWayB,
    output lookupReq, lookupIndex,
    input  tagCycle, readWr, tagIndex, dataIn,
    input  dataInParityBit, writeTagANotB,
    input  fillTagWrAck, lookupGnt,
    input  iccciBusy, iccciDone
  );

endinterface

// File: rtl/p405s_icu_tag_init_seq_parity.sv
// p405s_icu_tagParityGen: even parity (XOR reduction) over a tag word.
// Ports: i_data tag word, o_par XOR of all bits.
module p405s_icu_tagParityGen #(
  parameter int W = 22
) (
  input  logic [0:W-1] i_data,
  output logic         o_par
);

  assign o_par = ^i_data;

endmodule

// File: rtl/p405s_icu_tag_init_seq.sv
// p405s_icu_tag_init_seq: arbitrates the ICU tag-array port between the
// invalidate sweep, fill tag writes and lookup reads; all commands registered.
// Ports: CB clock, coreReset async active-high reset, bus (slave) carrying
// the requests in and the array command, acks and sweep status out.
module p405s_icu_tag_init_seq
  import p405s_icu_tag_init_seq_pkg::*;
#(
  parameter int IDX_W = ICU_TAG_IDX_W,
  parameter int TAG_W = ICU_TAG_W
) (
  input  logic                          CB,
  input  logic                          coreReset,
  p405s_icu_tag_init_seq_if.slave       bus
);

  tis_state_e       r_state, w_state_n;
  logic [IDX_W-1:0] r_cnt, w_cnt_n;
  tis_flags_t       r_flg, w_flg_n;
  logic [0:IDX_W]   r_idx, w_idx_n;
  logic [0:TAG_W-1] r_data, w_data_n;
  logic [0:TAG_W]   r_wsel, w_wsel_n;
  logic             w_par;

  always_ff @(posedge CB or posedge coreReset) begin
    if (coreReset) begin
      r_state <= ICU_TIS_SWEEP_A;
      r_cnt   <= '0;
      r_flg   <= TIS_FLAGS_RST;
      r_idx   <= '0;
      r_data  <= '0;
      r_wsel  <= '1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_flg   <= w_flg_n;
      r_idx   <= w_idx_n;
      r_data  <= w_data_n;
      r_wsel  <= w_wsel_n;
    end
  end

  // Default is "no command": read polarity, all bit-writes masked.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_flg_n   = TIS_FLAGS_RST;
    w_idx_n   = '0;
    w_data_n  = '0;
    w_wsel_n  = '1;
    unique case (r_state)
      ICU_TIS_SWEEP_A: begin
        w_flg_n.cyc = 1'b1;
        w_flg_n.rd  = 1'b0;
        w_idx_n     = {1'b0, r_cnt};
        w_data_n    = TAG_W'(ICU_TAG_INV);
        w_wsel_n    = '0;
        w_state_n   = ICU_TIS_SWEEP_B;
      end
      ICU_TIS_SWEEP_B: begin
        w_flg_n.cyc = 1'b1;
        w_flg_n.rd  = 1'b0;
        w_idx_n     = {1'b0, r_cnt};
        w_data_n    = TAG_W'(ICU_TAG_INV);
        w_wsel_n    = '1;
        if (&r_cnt) begin
          w_state_n = ICU_TIS_DONE;
        end else begin
          w_cnt_n   = r_cnt + IDX_W'(1);
          w_state_n = ICU_TIS_SWEEP_A;
        end
      end
      ICU_TIS_DONE: begin
        w_flg_n.done = 1'b1;
        w_state_n    = ICU_TIS_IDLE;
      end
      ICU_TIS_IDLE: begin
        w_flg_n.busy = 1'b0;
        priority case (1'b1)
          bus.iccciReq: begin
            w_cnt_n      = '0;
            w_flg_n.busy = 1'b1;
            w_state_n    = ICU_TIS_SWEEP_A;
          end
          bus.fillTagWrReq: begin
            w_flg_n.cyc = 1'b1;
            w_flg_n.rd  = 1'b0;
            w_flg_n.ack = 1'b1;
            w_idx_n     = bus.fillTagIndex;
            w_data_n    = bus.fillTagData;
            w_wsel_n    = {(TAG_W+1){bus.fillWayB}};
          end
          bus.lookupReq: begin
            w_flg_n.cyc = 1'b1;
            w_flg_n.gnt = 1'b1;
            w_idx_n     = bus.lookupIndex;
          end
          default: ;
        endcase
      end
    endcase
  end

  // Parity taken from the data register so both leave together.
  p405s_icu_tagParityGen #(
    .W (TAG_W)
  ) u_par (
    .i_data (r_data),
    .o_par  (w_par)
  );

  assign bus.tagCycle        = r_flg.cyc;
  assign bus.readWr          = r_flg.rd;
  assign bus.tagIndex        = r_idx;
  assign bus.dataIn          = r_data;
  assign bus.dataInParityBit = w_par;
  assign bus.writeTagANotB   = r_wsel;
  assign bus.fillTagWrAck    = r_flg.ack;
  assign bus.lookupGnt       = r_flg.gnt;
  assign bus.iccciBusy       = r_flg.busy;
  assign bus.iccciDone       = r_flg.done;

endmodule

// File: tb/tb_p405s_icu_tag_init_seq.sv
// tb_p405s_icu_tag_init_seq: table vectors, directed corner sequences and
// randomized requesters against a transaction-level reference model.
module tb_p405s_icu_tag_init_seq;

  logic CB;
  logic coreReset;

  p405s_icu_tag_init_seq_if #(.IDX_W(8), .TAG_W(22)) bus ();

  p405s_icu_tag_init_seq #(.IDX_W(8), .TAG_W(22)) dut (
    .CB        (CB),
    .coreReset (coreReset),
    .bus       (bus)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  typedef struct packed {
    logic        cyc;
    logic        rd;
    logic [8:0]  idx;
    logic [21:0] data;
    logic        par;
    logic [22:0] wsel;
    logic        ack;
    logic        gnt;
    logic        busy;
    logic        done;
  } out_t;

  typedef struct {
    logic        fill;
    logic [8:0]  fidx;
    logic [21:0] fdata;
    logic        wayB;
    logic        lk;
    logic [8:0]  lidx;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Reference model: sweep position k counts sweep commands issued so far.
  int   k;
  bit   dpend;
  bit   idle;
  out_t exp;

  out_t rst_out;
  vec_t vt[7];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.cyc  = bus.tagCycle;
    o.rd   = bus.readWr;
    o.idx  = bus.tagIndex;
    o.data = bus.dataIn;
    o.par  = bus.dataInParityBit;
    o.wsel = bus.writeTagANotB;
    o.ack  = bus.fillTagWrAck;
    o.gnt  = bus.lookupGnt;
    o.busy = bus.iccciBusy;
    o.done = bus.iccciDone;
    return o;
  endfunction

  function automatic out_t mk(bit cyc, bit rd, logic [8:0] idx,
                              logic [21:0] d, bit par, bit w1,
                              bit ack, bit gnt);
    out_t o;
    o      = '0;
    o.cyc  = cyc;
    o.rd   = rd;
    o.idx  = idx;
    o.data = d;
    o.par  = par;
    o.wsel = w1 ? '1 : '0;
    o.ack  = ack;
    o.gnt  = gnt;
    return o;
  endfunction

  function automatic vec_t mkv(bit fill, logic [8:0] fidx,
                               logic [21:0] fdata, bit wayB,
                               bit lk, logic [8:0] lidx, out_t e);
    vec_t v;
    v.fill  = fill;
    v.fidx  = fidx;
    v.fdata = fdata;
    v.wayB  = wayB;
    v.lk    = lk;
    v.lidx  = lidx;
    v.exp   = e;
    return v;
  endfunction

  // Predicts the array-side view after one rising edge from the inputs
  // presented before it.
  task automatic model_edge();
    exp      = '0;
    exp.rd   = 1'b1;
    exp.wsel = '1;
    if (coreReset) begin
      exp.busy = 1'b1;
      k     = 0;
      dpend = 0;
      idle  = 0;
    end else if (!idle && !dpend) begin
      exp.cyc  = 1'b1;
      exp.rd   = 1'b0;
      exp.idx  = 9'(k / 2);
      exp.wsel = (k % 2 == 1) ? '1 : '0;
      exp.busy = 1'b1;
      k++;
      if (k == 512) dpend = 1;
    end else if (dpend) begin
      exp.done = 1'b1;
      exp.busy = 1'b1;
      dpend = 0;
      idle  = 1;
    end else if (bus.iccciReq) begin
      exp.busy = 1'b1;
      idle = 0;
      k    = 0;
    end else if (bus.fillTagWrReq) begin
      exp.cyc  = 1'b1;
      exp.rd   = 1'b0;
      exp.idx  = bus.fillTagIndex;
      exp.data = bus.fillTagData;
      exp.wsel = bus.fillWayB ? '1 : '0;
      exp.ack  = 1'b1;
    end else if (bus.lookupReq) begin
      exp.cyc = 1'b1;
      exp.idx = bus.lookupIndex;
      exp.gnt = 1'b1;
    end
    exp.par = ^exp.data;
  endtask

  task automatic step();
    @(posedge CB);
    model_edge();
    #1;
    chk("model", 64'(sample()), 64'(exp));
  endtask

  task automatic clr_req();
    bus.iccciReq     = 1'b0;
    bus.fillTagWrReq = 1'b0;
    bus.fillTagIndex = '0;
    bus.fillTagData  = '0;
    bus.fillWayB     = 1'b0;
    bus.lookupReq    = 1'b0;
    bus.lookupIndex  = '0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 530 && !(idle && !dpend); i++) step();
    chk("reach_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    int writes, dones, done_c, ack_c;
    out_t s;

    rst_out = mk(0, 1, 9'h0, 22'h0, 0, 1, 0, 0);
    rst_out.busy = 1'b1;

    vt[0] = mkv(1, 9'h1A5, 22'h2A5A5A, 0, 0, 9'h0,
                mk(1, 0, 9'h1A5, 22'h2A5A5A, 1, 0, 1, 0));
    vt[1] = mkv(1, 9'h0FF, 22'h3FFFFF, 1, 0, 9'h0,
                mk(1, 0, 9'h0FF, 22'h3FFFFF, 0, 1, 1, 0));
    vt[2] = mkv(0, 9'h0, 22'h0, 0, 1, 9'h123,
                mk(1, 1, 9'h123, 22'h0, 0, 1, 0, 1));
    vt[3] = mkv(0, 9'h0, 22'h0, 0, 0, 9'h0,
                mk(0, 1, 9'h0, 22'h0, 0, 1, 0, 0));
    vt[4] = mkv(1, 9'h000, 22'h000001, 1, 0, 9'h0,
                mk(1, 0, 9'h000, 22'h000001, 1, 1, 1, 0));
    vt[5] = mkv(0, 9'h0, 22'h0, 0, 1, 9'h1FF,
                mk(1, 1, 9'h1FF, 22'h0, 0, 1, 0, 1));
    vt[6] = mkv(1, 9'h100, 22'h200000, 0, 0, 9'h0,
                mk(1, 0, 9'h100, 22'h200000, 1, 0, 1, 0));

    k = 0; dpend = 0; idle = 0; exp = '0;
    clr_req();
    coreReset = 1'b1;

    step();
    step();
    chk("reset_values", 64'(sample()), 64'(rst_out));

    // Sweep after reset release, no requests.
    coreReset = 1'b0;
    writes = 0; dones = 0; done_c = 0;
    for (int c = 1; c <= 515; c++) begin
      step();
      s = sample();
      if (s.cyc && !s.rd) writes++;
      if (s.done) begin dones++; done_c = c; end
    end
    chk("sweep_writes", 64'(writes), 64'd512);
    chk("done_cycle", 64'(done_c), 64'd513);
    chk("done_count", 64'(dones), 64'd1);
    chk("busy_after", 64'(bus.iccciBusy), 64'd0);

    // Table vectors applied in IDLE.
    foreach (vt[i]) begin
      bus.fillTagWrReq = vt[i].fill;
      bus.fillTagIndex = vt[i].fidx;
      bus.fillTagData  = vt[i].fdata;
      bus.fillWayB     = vt[i].wayB;
      bus.lookupReq    = vt[i].lk;
      bus.lookupIndex  = vt[i].lidx;
      step();
      chk($sformatf("vec%0d", i), 64'(sample()), 64'(vt[i].exp));
      clr_req();
      step();
    end

    // Simultaneous fill and lookup: fill first, lookup next cycle.
    bus.fillTagWrReq = 1'b1;
    bus.fillTagIndex = 9'h0AA;
    bus.fillTagData  = 22'h155555;
    bus.fillWayB     = 1'b1;
    bus.lookupReq    = 1'b1;
    bus.lookupIndex  = 9'h133;
    step();
    s = sample();
    chk("sim_fill_first", {62'd0, s.ack, s.gnt}, 64'd2);
    bus.fillTagWrReq = 1'b0;
    step();
    s = sample();
    chk("sim_lookup_next",
        {39'd0, s.ack, s.gnt, s.rd, s.wsel},
        {39'd0, 1'b0, 1'b1, 1'b1, 23'h7FFFFF});
    chk("sim_lookup_idx", 64'(s.idx), 64'h133);
    clr_req();
    step();

    // iccciReq in IDLE; fill held from cycle 5; iccciReq again at cnt=100.
    bus.iccciReq = 1'b1;
    step();
    bus.iccciReq = 1'b0;
    s = sample();
    chk("iccci_start", {62'd0, s.cyc, s.busy}, 64'd1);
    writes = 0; dones = 0; done_c = 0; ack_c = 0;
    for (int c = 1; c <= 520; c++) begin
      if (k == 5 && !idle) begin
        bus.fillTagWrReq = 1'b1;
        bus.fillTagIndex = 9'h155;
        bus.fillTagData  = 22'h2A5A5A;
        bus.fillWayB     = 1'b1;
      end
      bus.iccciReq = (k == 201 && !idle && !dpend);
      step();
      s = sample();
      if (s.cyc && !s.rd && !s.ack) writes++;
      if (s.done) begin dones++; done_c = c; end
      if (s.ack) begin
        ack_c = c;
        chk("fill_idx", 64'(s.idx), 64'h155);
        chk("fill_data", 64'(s.data), 64'h2A5A5A);
        chk("fill_par", 64'(s.par), 64'd1);
        chk("fill_way", 64'(s.wsel), 64'h7FFFFF);
        bus.fillTagWrReq = 1'b0;
      end
    end
    bus.iccciReq = 1'b0;
    chk("iccci_writes", 64'(writes), 64'd512);
    chk("iccci_dones", 64'(dones), 64'd1);
    chk("fill_after_done", 64'(ack_c), 64'(done_c + 1));

    // Reset while SWEEP_B holds cnt=37.
    coreReset = 1'b1;
    step();
    coreReset = 1'b0;
    for (int i = 0; i < 100 && k != 75; i++) step();
    chk("reach_cnt37", 64'(k), 64'd75);
    #2;
    coreReset = 1'b1;
    #1;
    chk("async_reset", 64'(sample()), 64'(rst_out));
    step();
    coreReset = 1'b0;
    step();
    s = sample();
    chk("restart_idx0_wayA",
        {39'd0, s.cyc, s.rd, s.idx, s.wsel[22], s.wsel[0]},
        {39'd0, 1'b1, 1'b0, 9'h0, 1'b0, 1'b0});
    run_to_idle();

    // Randomized requesters, occasional invalidates and resets.
    for (int c = 0; c < 2500; c++) begin
      bus.iccciReq = ($urandom_range(0, 399) == 0);
      step();
      if (exp.ack) bus.fillTagWrReq = 1'b0;
      if (exp.gnt) bus.lookupReq = 1'b0;
      if (!bus.fillTagWrReq && $urandom_range(0, 2) == 0) begin
        bus.fillTagWrReq = 1'b1;
        bus.fillTagIndex = 9'($urandom);
        bus.fillTagData  = 22'($urandom);
        bus.fillWayB     = 1'($urandom);
      end
      if (!bus.lookupReq && $urandom_range(0, 2) == 0) begin
        bus.lookupReq   = 1'b1;
        bus.lookupIndex = 9'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        coreReset = 1'b1;
        #1;
        chk("rand_async_reset", 64'(sample()), 64'(rst_out));
        step();
        coreReset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
